div_unit: RTL and testbench

Multi-cycle integer divider, the inverse of the ALU's single-cycle multiply path. It computes the quotient and remainder of two WIDTH-bit operands, signed or unsigned, using a radix-2 restoring algorithm, one quotient bit per cycle. It sits beside the ALU in the execute stage and writes its results to the HI/LO pair: quotient to LO, remainder to HI. The core stalls on `busy` and captures the results on `done`.

---
 rtl/div_unit_pkg.sv | 12 +
 rtl/div_unit_step.sv | 24 ++
 rtl/div_unit.sv | 136 +++++++++++++
 tb/tb_div_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage divider: state encodings and default width.
package div_unit_pkg;

    localparam int DIV_W = 32;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_CALC = 2'd1,
        DIV_ST_FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring iteration: shift {rem, dividend}, trial subtract, restore on borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_dvd,
    input  logic [WIDTH-1:0] i_dsr,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_dvd
);

    logic [WIDTH+1:0] w_rem_sh;
    logic [WIDTH+1:0] w_diff;
    logic             w_ge;

    // One extra bit above the shifted remainder makes the borrow visible as the sign bit.
    assign w_rem_sh = {i_rem, i_dvd[WIDTH-1]};
    assign w_diff   = w_rem_sh - {2'b00, i_dsr};
    assign w_ge     = ~w_diff[WIDTH+1];

    assign o_rem = w_ge ? w_diff[WIDTH:0] : w_rem_sh[WIDTH:0];
    assign o_dvd = {i_dvd[WIDTH-2:0], w_ge};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider; quotient goes to LO (o_q), remainder to HI (o_r).
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_sign,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_r,
    output logic             o_div_zero,
    output logic [1:0]       o_dbg_state
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       r_state;
    div_state_t       w_next;
    logic             w_load;
    logic             w_step;
    logic             w_fix;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dsr;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_div_zero;
    logic             r_done;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_step_rem;
    logic [WIDTH-1:0] w_step_dvd;

    // Unary minus of the most negative value wraps to itself, which is the magnitude we want.
    assign w_a_mag = (i_sign && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_b_mag = (i_sign && i_b[WIDTH-1]) ? -i_b : i_b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_dvd (r_dvd),
        .i_dsr (r_dsr),
        .o_rem (w_step_rem),
        .o_dvd (w_step_dvd)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= DIV_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        w_fix  = 1'b0;
        case (r_state)
            DIV_ST_IDLE: begin
                if (i_start) begin
                    w_load = 1'b1;
                    w_next = DIV_ST_CALC;
                end
            end
            DIV_ST_CALC: begin
                w_step = 1'b1;
                if (r_cnt == '0) begin
                    w_next = DIV_ST_FIX;
                end
            end
            DIV_ST_FIX: begin
                w_fix  = 1'b1;
                w_next = DIV_ST_IDLE;
            end
            default: begin
                w_next = DIV_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_dsr      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_q        <= '0;
            r_r        <= '0;
            r_div_zero <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_rem   <= '0;
                r_dvd   <= w_a_mag;
                r_dsr   <= w_b_mag;
                r_neg_q <= i_sign & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                r_neg_r <= i_sign & i_a[WIDTH-1];
                r_cnt   <= CW'(WIDTH - 1);
            end else if (w_step) begin
                r_rem <= w_step_rem;
                r_dvd <= w_step_dvd;
                r_cnt <= r_cnt - CW'(1);
            end else if (w_fix) begin
                // Quotient truncates toward zero; remainder takes the dividend's sign.
                r_q        <= r_neg_q ? -r_dvd : r_dvd;
                r_r        <= r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
                r_div_zero <= (r_dsr == '0);
                r_done     <= 1'b1;
            end
        end
    end

    // The done cycle is already IDLE, so busy is extended through it explicitly.
    assign o_busy      = (r_state != DIV_ST_IDLE) || r_done;
    assign o_done      = r_done;
    assign o_q         = r_q;
    assign o_r         = r_r;
    assign o_div_zero  = r_div_zero;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit with a queue-based scoreboard checked by a done monitor.
module tb_div_unit;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sign;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         div_zero;
    logic [1:0]   dbg_state;

    exp_t exp_q[$];
    int   lat_q[$];
    int   cyc;
    int   vectors;
    int   miscompares;

    div_unit #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_sign      (sign),
        .i_a         (a),
        .i_b         (b),
        .o_busy      (busy),
        .o_done      (done),
        .o_q         (q),
        .o_r         (r),
        .o_div_zero  (div_zero),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver: call at a negedge; returns at the negedge after the acceptance edge
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                         input bit push);
        exp_t e;
        start = 1'b1;
        sign  = is;
        a     = ia;
        b     = ib;
        if (push) begin
            e.q  = eq;
            e.r  = er;
            e.dz = edz;
            exp_q.push_back(e);
            lat_q.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = '0;
        b     = '0;
        sign  = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_timeout", W'(seen), W'(1));
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", W'(1), W'(0));
            end else begin
                exp_t e;
                int   t0;
                e  = exp_q.pop_front();
                t0 = lat_q.pop_front();
                check("q", q, e.q);
                check("r", r, e.r);
                check("div_zero", W'(div_zero), W'(e.dz));
                check("latency", W'(cyc - t0), W'(LAT));
                check("busy_at_done", W'(busy), W'(1));
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        sign        = 1'b0;
        a           = '0;
        b           = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_q", q, W'(0));
        check("rst_r", r, W'(0));
        check("rst_div_zero", W'(div_zero), W'(0));

        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1);                       wait_done();
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1);  wait_done();
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 1);          wait_done();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1);  wait_done();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 1);  wait_done();
        issue(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);                  wait_done();
        issue(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1);                          wait_done();
        issue(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1);  wait_done();
        issue(32'd0, 32'd5, 1'b1, 32'd0, 32'd0, 1'b0, 1);                          wait_done();
        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);          wait_done();
        issue(32'hFFFF_FFF8, 32'd0, 1'b1, 32'd1, 32'hFFFF_FFF8, 1'b1, 1);          wait_done();

        // start while busy must be ignored and must not disturb the running operands
        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1);
        repeat (8) @(negedge clk);
        issue(32'd9, 32'd4, 1'b0, 32'd0, 32'd0, 1'b0, 0);
        wait_done();
        repeat (40) @(negedge clk);
        check("idle_after_ignored", W'(busy), W'(0));

        // back-to-back: second start lands in the done cycle
        issue(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 1);
        wait_done();
        issue(32'd123, 32'd10, 1'b0, 32'd12, 32'd3, 1'b0, 1);
        check("busy_after_b2b", W'(busy), W'(1));
        wait_done();
        @(negedge clk);
        check("busy_falls", W'(busy), W'(0));

        // reset mid-operation aborts without a done
        issue(32'd20, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, 0);
        repeat (13) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", W'(busy), W'(0));
        check("abort_done", W'(done), W'(0));
        check("abort_q", q, W'(0));
        check("abort_r", r, W'(0));
        check("abort_div_zero", W'(div_zero), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("abort_no_busy", W'(busy), W'(0));

        issue(32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0, 1);
        wait_done();
        repeat (5) @(negedge clk);
        check("leftover_expected", W'(exp_q.size()), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
